// File: rtl/axil_read_master.sv
// rtl/axil_read_master.sv - AXI4-Lite read master with in-flight tracking, registered response and sticky timeout
module axil_read_master #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETn,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [ADDR_WIDTH-1:0]                    req_addr,
  input  logic [2:0]                               req_prot,
  output logic                                     ARVALID,
  input  logic                                     ARREADY,
  output logic [ADDR_WIDTH-1:0]                    ARADDR,
  output logic [2:0]                               ARPROT,
  input  logic                                     RVALID,
  output logic                                     RREADY,
  input  logic [DATA_WIDTH-1:0]                    RDATA,
  input  logic [1:0]                               RRESP,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [DATA_WIDTH-1:0]                    rsp_data,
  output logic                                     rsp_err,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic                                     timeout
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  // One extra bit so outstanding plus a pending AR cannot wrap in the compare.
  localparam int CW = OW + 1;
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
  // A zero timeout disables the timer; keep at least one bit so the vector is legal.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic          req_hs;
  logic          ar_hs;
  logic          r_hs;
  logic          rsp_hs;
  logic [CW-1:0] committed;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          timeout_d;
  logic          unused_rresp0;

  // Only the upper RRESP bit distinguishes error responses from OKAY/EXOKAY.
  assign unused_rresp0 = RRESP[0];

  assign req_hs = req_valid && req_ready;
  assign ar_hs  = ARVALID && ARREADY;
  assign r_hs   = RVALID && RREADY;
  assign rsp_hs = rsp_valid && rsp_ready;

  // A queued-but-unissued AR already claims an in-flight slot.
  assign committed = {1'b0, outstanding} + CW'(ARVALID);
  assign req_ready = (!ARVALID || ARREADY) && (committed < MAX_OUT);

  // Never accept read data unless a read is in flight and the response slot can take it.
  assign RREADY = (outstanding != '0) && (!rsp_valid || rsp_ready);

  // AR output register: load on request, drop valid once issued, hold while stalled.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      ARVALID <= 1'b0;
      ARADDR  <= '0;
      ARPROT  <= '0;
    end else if (req_hs) begin
      ARVALID <= 1'b1;
      ARADDR  <= req_addr;
      ARPROT  <= req_prot;
    end else if (ar_hs) begin
      ARVALID <= 1'b0;
    end
  end

  // In-flight count: AR handshakes minus R handshakes.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      outstanding <= '0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Response register: captures R beats in issue order, holds under backpressure.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (r_hs) begin
      rsp_valid <= 1'b1;
      rsp_data  <= RDATA;
      rsp_err   <= RRESP[1];
    end else if (rsp_hs) begin
      rsp_valid <= 1'b0;
    end
  end

  // Idle timer: saturating count of cycles with reads pending and no data returning.
  always_comb begin
    timer_d   = timer_q;
    timeout_d = timeout;
    if (TIMEOUT_CYCLES == 0) begin
      timer_d = '0;
    end else if (r_hs || (outstanding == '0)) begin
      timer_d = '0;
    end else if (timer_q != TMAX) begin
      timer_d = timer_q + 1'b1;
    end
    if ((TIMEOUT_CYCLES != 0) && (timer_d == TMAX)) begin
      timeout_d = 1'b1;
    end
  end

  // Timer and sticky flag state; only reset clears the flag.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      timer_q <= '0;
      timeout <= 1'b0;
    end else begin
      timer_q <= timer_d;
      timeout <= timeout_d;
    end
  end

endmodule
